// File: rtl/inst_mem_arbiter_pkg.sv
// rtl/inst_mem_arbiter_pkg.sv - shared encodings and helpers for the instruction memory arbiter
package inst_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LSU  = 2'd2
  } owner_t;

  // Counter width able to hold 0..max_streak; never narrower than one bit.
  function automatic int streak_w(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/inst_arb_fair.sv
// rtl/inst_arb_fair.sv - LSU-priority grant with a streak limit that guarantees fetch progress
module inst_arb_fair
  import inst_mem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic lsu_req,
  input  logic enable,
  output logic if_gnt,
  output logic lsu_gnt
);

  localparam int SW = streak_w(MAX_STREAK);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak;

  always_comb begin
    lsu_gnt = enable && lsu_req && !(if_req && (streak == STREAK_MAX));
    if_gnt  = enable && if_req && !lsu_gnt;
  end

  // Streak only counts LSU wins that actually starved a waiting fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (if_gnt || !if_req) begin
      streak <= '0;
    end else if (lsu_gnt && (streak != STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// rtl/inst_mem_arbiter.sv - instruction memory arbiter: boot loader, fetch and LSU sharing one port
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          MAX_STREAK = 3,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          BOOT_LOAD  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvld,
  output logic [31:0]       if_rdata,
  input  logic              lsu_req,
  input  logic [ADDR_W-1:0] lsu_addr,
  output logic              lsu_gnt,
  output logic              lsu_rvld,
  output logic [31:0]       lsu_rdata,
  input  logic              ld_wr_vld,
  input  logic [ADDR_W-1:0] ld_wr_addr,
  input  logic [31:0]       ld_wr_data,
  output logic              ld_wr_rdy,
  input  logic              ld_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              boot_busy,
  output logic              if_redirect,
  output logic [31:0]       if_redirect_addr
);

  localparam state_t RESET_ST = BOOT_LOAD ? ST_BOOT : ST_RUN;

  state_t state;
  owner_t owner;

  inst_arb_fair #(
    .MAX_STREAK(MAX_STREAK)
  ) u_fair (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_req (if_req),
    .lsu_req(lsu_req),
    .enable (state == ST_RUN),
    .if_gnt (if_gnt),
    .lsu_gnt(lsu_gnt)
  );

  // A write presented alongside ld_done still lands because the mux below follows the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_ST;
      if_redirect <= 1'b0;
      boot_busy   <= BOOT_LOAD;
    end else begin
      case (state)
        ST_BOOT: begin
          if (ld_done) begin
            state       <= ST_FLUSH;
            if_redirect <= 1'b1;
          end
        end
        ST_FLUSH: begin
          state       <= ST_RUN;
          if_redirect <= 1'b0;
          boot_busy   <= 1'b0;
        end
        default: begin
          state       <= ST_RUN;
          if_redirect <= 1'b0;
          boot_busy   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_NONE;
    end else if (if_gnt) begin
      owner <= OWN_IF;
    end else if (lsu_gnt) begin
      owner <= OWN_LSU;
    end else begin
      owner <= OWN_NONE;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_wr_rdy = 1'b0;
    case (state)
      ST_BOOT: begin
        ld_wr_rdy = 1'b1;
        mem_en    = ld_wr_vld;
        mem_we    = ld_wr_vld;
        mem_addr  = ld_wr_addr;
        mem_wdata = ld_wr_data;
      end
      ST_RUN: begin
        mem_en = if_gnt | lsu_gnt;
        if (lsu_gnt) begin
          mem_addr = lsu_addr;
        end else if (if_gnt) begin
          mem_addr = if_addr;
        end
      end
      default: ;
    endcase
  end

  assign if_rvld          = (owner == OWN_IF);
  assign lsu_rvld         = (owner == OWN_LSU);
  assign if_rdata         = mem_rdata;
  assign lsu_rdata        = mem_rdata;
  assign if_redirect_addr = RESET_PC;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// tb/tb_inst_mem_arbiter.sv - directed scoreboard bench for inst_mem_arbiter
module tb_inst_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int MAXS   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, lsu_req, ld_wr_vld, ld_done;
  logic [ADDR_W-1:0] if_addr, lsu_addr, ld_wr_addr;
  logic [31:0]       ld_wr_data;

  logic              if_gnt, if_rvld, lsu_gnt, lsu_rvld, ld_wr_rdy;
  logic              mem_en, mem_we, boot_busy, if_redirect;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       if_rdata, lsu_rdata, mem_wdata, if_redirect_addr;
  logic [31:0]       mem_rdata;

  logic              d0_if_gnt, d0_if_rvld, d0_lsu_gnt, d0_lsu_rvld, d0_ld_wr_rdy;
  logic              d0_mem_en, d0_mem_we, d0_boot_busy, d0_if_redirect;
  logic [ADDR_W-1:0] d0_mem_addr;
  logic [31:0]       d0_if_rdata, d0_lsu_rdata, d0_mem_wdata, d0_if_redirect_addr;

  always #5 clk = ~clk;

  inst_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_STREAK(MAXS), .RESET_PC(32'h0), .BOOT_LOAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvld(if_rvld), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_gnt(lsu_gnt), .lsu_rvld(lsu_rvld), .lsu_rdata(lsu_rdata),
    .ld_wr_vld(ld_wr_vld), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data), .ld_wr_rdy(ld_wr_rdy),
    .ld_done(ld_done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .boot_busy(boot_busy), .if_redirect(if_redirect),
    .if_redirect_addr(if_redirect_addr)
  );

  inst_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_STREAK(MAXS), .RESET_PC(32'h0), .BOOT_LOAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(d0_if_gnt), .if_rvld(d0_if_rvld), .if_rdata(d0_if_rdata),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_gnt(d0_lsu_gnt), .lsu_rvld(d0_lsu_rvld),
    .lsu_rdata(d0_lsu_rdata), .ld_wr_vld(ld_wr_vld), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
    .ld_wr_rdy(d0_ld_wr_rdy), .ld_done(ld_done), .mem_en(d0_mem_en), .mem_we(d0_mem_we),
    .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata), .mem_rdata(32'h0), .boot_busy(d0_boot_busy),
    .if_redirect(d0_if_redirect), .if_redirect_addr(d0_if_redirect_addr)
  );

  // Synchronous-read single-port memory behind the main instance.
  logic [31:0] mem [2**ADDR_W];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [2**ADDR_W];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_streak = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One RUN cycle: predict and check grants, queue the expected return, then check the return.
  task automatic run_cycle();
    logic ei, el;
    exp_t e;
    #3;
    el = lsu_req && (!if_req || m_streak != MAXS);
    ei = if_req && !el;
    check("if_gnt", {31'd0, if_gnt}, {31'd0, ei});
    check("lsu_gnt", {31'd0, lsu_gnt}, {31'd0, el});
    check("run_mem_en", {31'd0, mem_en}, {31'd0, ei | el});
    check("run_mem_we", {31'd0, mem_we}, 32'd0);
    if (el)      check("lsu_mem_addr", 32'(mem_addr), 32'(lsu_addr));
    else if (ei) check("if_mem_addr", 32'(mem_addr), 32'(if_addr));
    if (ei)      sb.push_back('{2'd1, ref_mem[if_addr]});
    else if (el) sb.push_back('{2'd2, ref_mem[lsu_addr]});
    else         sb.push_back('{2'd0, 32'd0});
    if (ei || !if_req)              m_streak = 0;
    else if (el && m_streak < MAXS) m_streak++;
    @(posedge clk); #1;
    e = sb.pop_front();
    check("if_rvld", {31'd0, if_rvld}, {31'd0, e.tag == 2'd1});
    check("lsu_rvld", {31'd0, lsu_rvld}, {31'd0, e.tag == 2'd2});
    if (e.tag == 2'd1) check("if_rdata", if_rdata, e.data);
    if (e.tag == 2'd2) check("lsu_rdata", lsu_rdata, e.data);
  endtask

  task automatic boot_cycle(input logic vld, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic done);
    ld_wr_vld = vld; ld_wr_addr = a; ld_wr_data = d; ld_done = done;
    #3;
    check("boot_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("boot_lsu_gnt", {31'd0, lsu_gnt}, 32'd0);
    check("boot_mem_we", {31'd0, mem_we}, {31'd0, vld});
    check("boot_mem_en", {31'd0, mem_en}, {31'd0, vld});
    check("boot_rdy", {31'd0, ld_wr_rdy}, 32'd1);
    check("boot_busy", {31'd0, boot_busy}, 32'd1);
    if (vld) begin
      check("boot_mem_addr", 32'(mem_addr), 32'(a));
      check("boot_mem_wdata", mem_wdata, d);
      ref_mem[a] = d;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    rst_n = 1'b0; if_req = 0; lsu_req = 0; ld_wr_vld = 0; ld_done = 0;
    if_addr = '0; lsu_addr = '0; ld_wr_addr = '0; ld_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_boot_busy", {31'd0, boot_busy}, 32'd1);
    check("rst_redirect", {31'd0, if_redirect}, 32'd0);
    check("rst_if_rvld", {31'd0, if_rvld}, 32'd0);
    check("rst_lsu_rvld", {31'd0, lsu_rvld}, 32'd0);
    check("rst_ld_rdy", {31'd0, ld_wr_rdy}, 32'd1);
    check("rst0_boot_busy", {31'd0, d0_boot_busy}, 32'd0);
    check("rst0_ld_rdy", {31'd0, d0_ld_wr_rdy}, 32'd0);
    check("rst0_redirect_addr", d0_if_redirect_addr, 32'd0);
    rst_n = 1'b1;

    // Boot load with both readers requesting throughout; last write coincides with ld_done.
    if_req = 1; lsu_req = 1; if_addr = 10'd2; lsu_addr = 10'd5;
    for (int i = 0; i < 3; i++) boot_cycle(1'b1, ADDR_W'(i), 32'h0000_0013, 1'b0);
    boot_cycle(1'b0, 10'd7, 32'hDEAD_BEEF, 1'b0);
    boot_cycle(1'b1, 10'd3, 32'h0000_0013, 1'b1);
    ld_wr_vld = 0; ld_done = 0;
    #3;
    check("flush_redirect", {31'd0, if_redirect}, 32'd1);
    check("flush_redirect_addr", if_redirect_addr, 32'd0);
    check("flush_busy", {31'd0, boot_busy}, 32'd1);
    check("flush_if_gnt", {31'd0, if_gnt}, 32'd0);
    check("flush_lsu_gnt", {31'd0, lsu_gnt}, 32'd0);
    check("flush_mem_en", {31'd0, mem_en}, 32'd0);
    @(posedge clk); #1;
    check("run_redirect", {31'd0, if_redirect}, 32'd0);
    check("run_busy", {31'd0, boot_busy}, 32'd0);
    check("run_ld_rdy", {31'd0, ld_wr_rdy}, 32'd0);

    // Fairness: expect LSU,LSU,LSU,IF twice; fetch reads word 2, LSU reads word 5.
    for (int i = 0; i < 8; i++) run_cycle();

    // Fetch alone on word 3 (written together with ld_done) and on the top word.
    lsu_req = 0; if_addr = 10'd3;
    run_cycle();
    if_addr = 10'd1023;
    run_cycle();

    // LSU alone keeps the streak at zero, so a following contention starts with three LSU wins.
    if_req = 0; lsu_req = 1; lsu_addr = 10'd1;
    for (int i = 0; i < 5; i++) run_cycle();
    if_req = 1; if_addr = 10'd0;
    for (int i = 0; i < 4; i++) run_cycle();
    lsu_req = 0;
    run_cycle();

    // Loader is ignored in RUN.
    if_req = 0; ld_wr_vld = 1; ld_wr_addr = 10'd0; ld_wr_data = 32'hBAD0_BAD0; ld_done = 1;
    run_cycle();
    ld_wr_vld = 0; ld_done = 0;
    if_addr = 10'd0; if_req = 1;
    run_cycle();

    // Reset between an LSU grant and its return.
    if_req = 1; lsu_req = 1;
    run_cycle();
    #3;
    check("pre_rst_lsu_gnt", {31'd0, lsu_gnt}, 32'd1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_lsu_rvld", {31'd0, lsu_rvld}, 32'd0);
    check("mid_rst_if_rvld", {31'd0, if_rvld}, 32'd0);
    check("mid_rst_busy", {31'd0, boot_busy}, 32'd1);
    check("mid_rst_ld_rdy", {31'd0, ld_wr_rdy}, 32'd1);
    check("mid_rst0_busy", {31'd0, d0_boot_busy}, 32'd0);
    check("mid_rst0_lsu_rvld", {31'd0, d0_lsu_rvld}, 32'd0);
    check("mid_rst0_mem_we", {31'd0, d0_mem_we}, 32'd0);
    check("mid_rst0_redirect", {31'd0, d0_if_redirect}, 32'd0);
    sb.delete();
    m_streak = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      check("post_rst_if_gnt", {31'd0, if_gnt}, 32'd0);
      check("post_rst_lsu_gnt", {31'd0, lsu_gnt}, 32'd0);
      check("post_rst0_lsu_gnt", {31'd0, d0_lsu_gnt}, {31'd0, i != 3});
      check("post_rst0_if_gnt", {31'd0, d0_if_gnt}, {31'd0, i == 3});
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
